vga_timing_ctrl: RTL and testbench

- Generates VGA 640x480@60 Hz timing from the 50 MHz board clock.
- Divides by 2 internally into a pixel-tick enable; no derived clock is produced.
- Sequences horizontal and vertical counters through active, front-porch, sync and back-porch phases.
- Drives hsync, vsync, the active-video flag and pixel coordinates to the pixel-generation logic and VGA pins.

---
 rtl/vga_timing_ctrl.sv | 79 +++++++
 tb/tb_vga_timing_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA timing from a 50 MHz clock; in clock50MHz/inReset/inEnable, out pixel tick, h/v sync, active flag, x/y, line/frame-start pulses
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clock50MHz,
  input  logic       inReset,
  input  logic       inEnable,
  output logic       outPixelTick,
  output logic       outHSync,
  output logic       outVSync,
  output logic       outActive,
  output logic [9:0] outX,
  output logic [9:0] outY,
  output logic       outLineStart,
  output logic       outFrameStart
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_ctrl: timing totals exceed 10-bit counters");
  end
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_TOT_END  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_TOT_END  = 10'(V_TOTAL - 1);
  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;
  logic       tick;
  logic [9:0] hcount, vcount, h_end, v_end;
  logic       h_wrap, v_wrap;
  h_state_t   h_state;
  v_state_t   v_state;
  always_comb begin
    h_end  = h_state == HS_ACT ? H_ACT_END : h_state == HS_FP ? H_FP_END : h_state == HS_SYNC ? H_SYNC_END : H_TOT_END;
    v_end  = v_state == VS_ACT ? V_ACT_END : v_state == VS_FP ? V_FP_END : v_state == VS_SYNC ? V_SYNC_END : V_TOT_END;
    h_wrap = hcount == H_TOT_END;
    v_wrap = vcount == V_TOT_END;
  end
  // Phases are listed in enum order, so leaving a phase is a 2-bit increment that wraps BP -> ACT.
  always_ff @(posedge clock50MHz) begin
    if (inReset) begin
      tick    <= 1'b0;
      hcount  <= '0;
      vcount  <= '0;
      h_state <= HS_ACT;
      v_state <= VS_ACT;
    end else if (inEnable) begin
      tick <= ~tick;
      if (tick) begin
        hcount <= h_wrap ? '0 : hcount + 10'd1;
        if (hcount == h_end) h_state <= h_state_t'(h_state + 2'd1);
        if (h_wrap) begin
          vcount <= v_wrap ? '0 : vcount + 10'd1;
          if (vcount == v_end) v_state <= v_state_t'(v_state + 2'd1);
        end
      end
    end
  end
  assign outPixelTick  = tick;
  assign outHSync      = h_state == HS_SYNC ? SYNC_POL : ~SYNC_POL;
  assign outVSync      = v_state == VS_SYNC ? SYNC_POL : ~SYNC_POL;
  assign outActive     = h_state == HS_ACT && v_state == VS_ACT;
  assign outX          = outActive ? hcount : '0;
  assign outY          = outActive ? vcount : '0;
  assign outLineStart  = tick && hcount == '0;
  assign outFrameStart = outLineStart && vcount == '0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized and directed checks of vga_timing_ctrl against an arithmetic timing model
module tb_vga_timing_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  int n = 0, cyc = 0, checks = 0, errors = 0;
  bit mon = 1'b0;
  logic d_tick, d_hs, d_vs, d_act, d_ls, d_fs, s_tick, s_hs, s_vs, s_act, s_ls, s_fs;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic [25:0] e_d, e_s;
  logic [23:0] i_d, i_s;
  always #10 clk = ~clk;
  vga_timing_ctrl dut (
    .clock50MHz(clk), .inReset(rst), .inEnable(en), .outPixelTick(d_tick), .outHSync(d_hs),
    .outVSync(d_vs), .outActive(d_act), .outX(d_x), .outY(d_y), .outLineStart(d_ls), .outFrameStart(d_fs)
  );
  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .SYNC_POL(1'b1)
  ) sml (
    .clock50MHz(clk), .inReset(rst), .inEnable(en), .outPixelTick(s_tick), .outHSync(s_hs),
    .outVSync(s_vs), .outActive(s_act), .outX(s_x), .outY(s_y), .outLineStart(s_ls), .outFrameStart(s_fs)
  );
  // n counts enabled clocks since reset: tick is its parity, pixel steps are n/2.
  always @(posedge clk) begin
    n   <= rst ? 0 : en ? n + 1 : n;
    cyc <= rst ? 0 : cyc + 1;
  end
  function automatic logic [25:0] exp_out(int k, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, logic pol);
    int s, h, v;
    logic t, act, ls;
    t = k[0];
    s = k / 2;
    h = s % (ha + hf + hs + hb);
    v = (s / (ha + hf + hs + hb)) % (va + vf + vs + vb);
    act = h < ha && v < va;
    ls = t && h == 0;
    return {t, (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol, (v >= va + vf && v < va + vf + vs) ? pol : ~pol,
            act, act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0, ls, ls && v == 0};
  endfunction
  function automatic logic [23:0] exp_int(int k, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    int s, h, v;
    s = k / 2;
    h = s % (ha + hf + hs + hb);
    v = (s / (ha + hf + hs + hb)) % (va + vf + vs + vb);
    return {10'(h), 10'(v), 2'(h < ha ? 0 : h < ha + hf ? 1 : h < ha + hf + hs ? 2 : 3),
            2'(v < va ? 0 : v < va + vf ? 1 : v < va + vf + vs ? 2 : 3)};
  endfunction
  always @(negedge clk) if (mon) begin
    e_d = exp_out(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    e_s = exp_out(n, 16, 4, 8, 4, 12, 3, 2, 4, 1'b1);
    i_d = exp_int(n, 640, 16, 96, 48, 480, 10, 2, 33);
    i_s = exp_int(n, 16, 4, 8, 4, 12, 3, 2, 4);
    checks += 4;
    if ({d_tick, d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs} !== e_d) begin
      errors++;
      $display("FAIL model_dut_out cyc=%0d got %h want %h", cyc, {d_tick, d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs}, e_d);
    end
    if ({s_tick, s_hs, s_vs, s_act, s_x, s_y, s_ls, s_fs} !== e_s) begin
      errors++;
      $display("FAIL model_sml_out cyc=%0d got %h want %h", cyc, {s_tick, s_hs, s_vs, s_act, s_x, s_y, s_ls, s_fs}, e_s);
    end
    if ({dut.hcount, dut.vcount, dut.h_state, dut.v_state} !== i_d) begin
      errors++;
      $display("FAIL model_dut_state cyc=%0d got %h want %h", cyc, {dut.hcount, dut.vcount, dut.h_state, dut.v_state}, i_d);
    end
    if ({sml.hcount, sml.vcount, sml.h_state, sml.v_state} !== i_s) begin
      errors++;
      $display("FAIL model_sml_state cyc=%0d got %h want %h", cyc, {sml.hcount, sml.vcount, sml.h_state, sml.v_state}, i_s);
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    mon = 1'b1;
    checks++;
    if ({d_tick, d_ls, d_fs, d_x, d_y} !== 23'd0) begin
      errors++;
      $display("FAIL reset_zero got %h want 0", {d_tick, d_ls, d_fs, d_x, d_y});
    end
    checks++;
    if ({d_hs, d_vs, d_act} !== 3'b111) begin
      errors++;
      $display("FAIL reset_dut_flags got %b want 111", {d_hs, d_vs, d_act});
    end
    checks++;
    if ({s_hs, s_vs, s_act} !== 3'b001) begin
      errors++;
      $display("FAIL reset_sml_flags got %b want 001", {s_hs, s_vs, s_act});
    end
    checks++;
    if ({dut.hcount, dut.vcount} !== 20'd0) begin
      errors++;
      $display("FAIL reset_counts got %h want 0", {dut.hcount, dut.vcount});
    end
  endtask
  task automatic test_line();
    int first = -1, last = -1, lows = 0, lsc = 0, lsbad = 0, tbad = 0;
    do_reset();
    repeat (1602) begin
      @(negedge clk);
      if (!d_hs) begin
        if (first < 0) first = cyc;
        last = cyc;
        lows++;
      end
      if (d_ls) begin
        lsc++;
        if (cyc != 1 && cyc != 1601) lsbad++;
      end
      if (d_tick !== cyc[0]) tbad++;
      if (cyc == 1278) begin
        checks++;
        if (d_x !== 10'd639 || d_act !== 1'b1) begin
          errors++;
          $display("FAIL last_pixel got x=%0d act=%b want x=639 act=1", d_x, d_act);
        end
      end
      if (cyc == 1280) begin
        checks++;
        if (d_x !== 10'd0 || d_act !== 1'b0) begin
          errors++;
          $display("FAIL first_blank got x=%0d act=%b want x=0 act=0", d_x, d_act);
        end
      end
    end
    checks++;
    if (first != 1312 || last != 1503 || lows != 192) begin
      errors++;
      $display("FAIL hsync_window got %0d..%0d n=%0d want 1312..1503 n=192", first, last, lows);
    end
    checks++;
    if (lsc != 2 || lsbad != 0) begin
      errors++;
      $display("FAIL line_start got count=%0d stray=%0d want 2 and 0", lsc, lsbad);
    end
    checks++;
    if (tbad != 0) begin
      errors++;
      $display("FAIL tick_toggle got %0d bad cycles want 0", tbad);
    end
  endtask
  task automatic test_frame();
    int first = -1, last = -1, highs = 0, fsc = 0, fsbad = 0, lsc = 0;
    do_reset();
    repeat (2700) begin
      @(negedge clk);
      if (s_vs && cyc < 1344) begin
        if (first < 0) first = cyc;
        last = cyc;
        highs++;
      end
      if (s_fs) begin
        fsc++;
        if (cyc % 1344 != 1) fsbad++;
      end
      if (s_ls) lsc++;
    end
    checks++;
    if (first != 960 || last != 1087 || highs != 128) begin
      errors++;
      $display("FAIL vsync_window got %0d..%0d n=%0d want 960..1087 n=128", first, last, highs);
    end
    checks++;
    if (fsc != 3 || fsbad != 0) begin
      errors++;
      $display("FAIL frame_start got count=%0d stray=%0d want 3 and 0", fsc, fsbad);
    end
    checks++;
    if (lsc != 43) begin
      errors++;
      $display("FAIL line_count got %0d want 43", lsc);
    end
  endtask
  task automatic test_freeze();
    int first = -1, last = -1, lows = 0, fbad = 0;
    logic [25:0] snap = '0;
    do_reset();
    repeat (1700) begin
      @(negedge clk);
      if (!d_hs) begin
        if (first < 0) first = cyc;
        last = cyc;
        lows++;
      end
      if (cyc > 1400 && cyc <= 1437 && {d_tick, d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs} !== snap) fbad++;
      if (cyc == 1400) begin
        snap = {d_tick, d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs};
        en = 1'b0;
      end
      if (cyc == 1437) en = 1'b1;
    end
    checks++;
    if (fbad != 0) begin
      errors++;
      $display("FAIL freeze_hold got %0d changed cycles want 0", fbad);
    end
    checks++;
    if (first != 1312 || last != 1540 || lows != 229) begin
      errors++;
      $display("FAIL freeze_hsync got %0d..%0d n=%0d want 1312..1540 n=229", first, last, lows);
    end
  endtask
  task automatic test_mid_reset();
    int first = -1, lsc = 0, lsbad = 0;
    do_reset();
    repeat (3333) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({d_tick, dut.hcount, dut.vcount, d_hs, d_vs, s_hs} !== {21'd0, 3'b110}) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", {d_tick, dut.hcount, dut.vcount, d_hs, d_vs, s_hs}, {21'd0, 3'b110});
    end
    repeat (1602) begin
      @(negedge clk);
      if (!d_hs && first < 0) first = cyc;
      if (d_ls) begin
        lsc++;
        if (cyc != 1 && cyc != 1601) lsbad++;
      end
    end
    checks++;
    if (first != 1312 || lsc != 2 || lsbad != 0) begin
      errors++;
      $display("FAIL restart got hs=%0d ls=%0d stray=%0d want 1312 2 0", first, lsc, lsbad);
    end
  endtask
  task automatic test_random();
    int bad = 0;
    do_reset();
    repeat (4000) begin
      @(negedge clk);
      if (s_x >= 10'd16 || s_y >= 10'd12 || d_x >= 10'd640 || d_y >= 10'd480) bad++;
      en = $urandom_range(0, 3) != 0;
    end
    en = 1'b1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL coord_range got %0d out-of-range cycles want 0", bad);
    end
  endtask
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_freeze();
    test_mid_reset();
    test_random();
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
